fpu_sgnj_stage: RTL and testbench
=================================

Name: fpu_sgnj_stage

Overview:
- Registered execute stage wrapping the FP sign-injection datapath: FSGNJ, FSGNJN, FSGNJX for single and double precision.
- Sits between the FPU issue logic (upstream) and the FP register-file writeback arbiter (downstream).
- Accepts one operation per cycle through a valid/ready handshake.
- Applies RISC-V NaN-boxing rules to single-precision operands held in 64-bit registers.
- Buffers results in a 2-entry output queue so downstream backpressure never drops an operation.

Parameters:
- BUS_WIDTH, 64, FP register width; only 64 is supported. Single precision uses bits [31:0] with NaN-boxing.
- TAG_WIDTH, 5, width of the destination register tag carried alongside each operation.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  issue side presents an operation.
- in_ready  output  1  stage can accept an operation this cycle.
- in_op  input  2  00 FSGNJ, 01 FSGNJN, 10 FSGNJX, 11 reserved.
- in_fmt  input  1  0 = single, 1 = double.
- in_rs1  input  BUS_WIDTH  operand 1 (magnitude source).
- in_rs2  input  BUS_WIDTH  operand 2 (sign source).
- in_tag  input  TAG_WIDTH  destination tag.
- out_valid  output  1  result available.
- out_ready  input  1  writeback accepts the result.
- out_data  output  BUS_WIDTH  result value.
- out_tag  output  TAG_WIDTH  tag of the result.
- out_illegal  output  1  result came from the reserved op.

Behaviour:
- Reset (rst_n low, asynchronous): queue empty; out_valid=0, out_data=0, out_tag=0, out_illegal=0; in_ready=1 on the first cycle after release.
- Accept: a transfer occurs when in_valid && in_ready at a rising edge. Pop: occurs when out_valid && out_ready at a rising edge.
- Queue: 2 entries, in-order, with count 0..2.
  - in_ready = (count != 2), registered from count and independent of out_ready.
  - out_valid = (count != 0).
  - out_data, out_tag and out_illegal always present the head entry. They are registered and hold stable while out_valid && !out_ready.
- Latency: accept in cycle N into an empty queue gives out_valid=1 in cycle N+1 with that result.
- Simultaneous push and pop:
  - count 1: count stays 1; the new entry becomes the head next cycle.
  - count 2: push is impossible because in_ready=0; the pop takes count to 1.
- Occupancy wrap: read and write pointers are 1 bit each and toggle mod 2.
- Double (in_fmt=1):
  - sign = rs2[63] for J, ~rs2[63] for JN, rs1[63]^rs2[63] for JX.
  - result = {sign, rs1[62:0]}.
- Single (in_fmt=0):
  - Each operand is unboxed: if rs[63:32] != 32'hFFFFFFFF, the operand is replaced by 32'h7FC00000; otherwise rs[31:0] is used.
  - The same sign rules apply on bit 31 of the unboxed values.
  - result = {32'hFFFFFFFF, sign, a[30:0]}.
- Reserved op (11): result = in_rs1 unchanged, out_illegal=1 for that entry. It is otherwise a normal transfer.
- NaN inputs: no special handling. The sign is injected and the payload is preserved, which includes canonical NaN substitution for bad boxing.
- Reset mid-operation: all queued entries are discarded and out_valid drops immediately (asynchronous).
- X-safety: no datapath register updates unless a push occurs.

Test Plan:
- Double FSGNJX, rs1=0x3FF0000000000000, rs2=0xC000000000000000, out_ready=1 -> next cycle out_valid=1, out_data=0xBFF0000000000000, tag echoed.
- Single FSGNJN, rs1=rs2=0xFFFFFFFF3F800000 -> out_data=0xFFFFFFFFBF800000.
- Single FSGNJ, rs1=0x000000003F800000 (unboxed), rs2=0xFFFFFFFFBF800000 -> out_data=0xFFFFFFFFFFC00000.
- Backpressure: out_ready=0, issue tags 1,2,3 back-to-back.
  - Expect in_ready=0 after 2 accepts and tag 3 held upstream.
  - Raise out_ready: outputs tags 1,2,3 in order, with exactly one result per cycle.
- Reserved op 11, rs1=0x123456789ABCDEF0, tag=7 -> out_data=0x123456789ABCDEF0, out_illegal=1; the following legal op has out_illegal=0.
- Assert rst_n low with 2 entries queued and out_ready=0 -> out_valid=0 in the same cycle.
  - After release: in_ready=1, count 0, and no stale result appears.

Source files
------------

// File: rtl/fpu_sgnj_stage.sv
// -----------------------------------------------------------------------------
// fpu_sgnj_stage
// Registered execute stage for the RISC-V FP sign-injection operations
// (FSGNJ / FSGNJN / FSGNJX, single and double precision). Results are held in
// a 2-entry in-order output queue, so downstream backpressure never drops an
// accepted operation.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     issue side presents an operation
//   in_ready     stage can accept an operation (registered, from occupancy)
//   in_op        00 FSGNJ, 01 FSGNJN, 10 FSGNJX, 11 reserved
//   in_fmt       0 = single (NaN-boxed in 64 bits), 1 = double
//   in_rs1       magnitude source operand
//   in_rs2       sign source operand
//   in_tag       destination register tag
//   out_valid    head result available
//   out_ready    writeback accepts the head result
//   out_data     head result value (registered)
//   out_tag      head result tag (registered)
//   out_illegal  head result came from the reserved opcode (registered)
// -----------------------------------------------------------------------------
module fpu_sgnj_stage #(
    parameter int BUS_WIDTH = 64,
    parameter int TAG_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_op,
    input  logic                 in_fmt,
    input  logic [BUS_WIDTH-1:0] in_rs1,
    input  logic [BUS_WIDTH-1:0] in_rs2,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BUS_WIDTH-1:0] out_data,
    output logic [TAG_WIDTH-1:0] out_tag,
    output logic                 out_illegal
);

    localparam logic [1:0] OP_SGNJ  = 2'b00;
    localparam logic [1:0] OP_SGNJN = 2'b01;
    localparam logic [1:0] OP_SGNJX = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    localparam logic [31:0] BOX_ONES  = 32'hFFFF_FFFF;
    localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

    // Unbox a single-precision operand; an improperly boxed value reads as
    // the canonical quiet NaN.
    function automatic logic [31:0] unbox(input logic [63:0] rs);
        logic [31:0] val;
        if (rs[63:32] == BOX_ONES) begin
            val = rs[31:0];
        end else begin
            val = CANON_NAN;
        end
        return val;
    endfunction

    // Full sign-injection result for one operation.
    function automatic logic [63:0] sgnj_result(
        input logic [1:0]  op,
        input logic        fmt,
        input logic [63:0] rs1,
        input logic [63:0] rs2
    );
        logic [31:0] a_val;
        logic [31:0] b_val;
        logic        sign_a;
        logic        sign_b;
        logic        sign;
        logic [63:0] res;
        a_val  = unbox(rs1);
        b_val  = unbox(rs2);
        sign_a = fmt ? rs1[63] : a_val[31];
        sign_b = fmt ? rs2[63] : b_val[31];
        case (op)
            OP_SGNJ:  sign = sign_b;
            OP_SGNJN: sign = ~sign_b;
            OP_SGNJX: sign = sign_a ^ sign_b;
            default:  sign = 1'b0;
        endcase
        if (op == OP_RSVD) begin
            res = rs1;
        end else if (fmt) begin
            res = {sign, rs1[62:0]};
        end else begin
            res = {BOX_ONES, sign, a_val[30:0]};
        end
        return res;
    endfunction

    // Queue storage and control state
    logic [BUS_WIDTH-1:0] mem_data_r [2];
    logic [TAG_WIDTH-1:0] mem_tag_r  [2];
    logic                 mem_ill_r  [2];
    logic                 wr_ptr_r;
    logic                 rd_ptr_r;
    logic [1:0]           count_r;
    logic                 in_ready_r;
    logic                 out_valid_r;
    logic [BUS_WIDTH-1:0] out_data_r;
    logic [TAG_WIDTH-1:0] out_tag_r;
    logic                 out_illegal_r;

    logic                 push_s;
    logic                 pop_s;
    logic [BUS_WIDTH-1:0] new_data_s;
    logic                 new_ill_s;
    logic [1:0]           count_n_s;
    logic                 rd_n_s;
    logic                 head_load_s;
    logic [BUS_WIDTH-1:0] head_data_s;
    logic [TAG_WIDTH-1:0] head_tag_s;
    logic                 head_ill_s;

    assign push_s     = in_valid && in_ready_r;
    assign pop_s      = out_valid_r && out_ready;
    assign new_data_s = sgnj_result(in_op, in_fmt, in_rs1, in_rs2);
    assign new_ill_s  = (in_op == OP_RSVD);
    assign rd_n_s     = rd_ptr_r ^ pop_s;

    // Next occupancy from the push/pop combination.
    always_comb begin
        count_n_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_n_s = count_r + 2'd1;
            2'b01:   count_n_s = count_r - 2'd1;
            default: count_n_s = count_r;
        endcase
    end

    // Next head entry: the incoming op bypasses storage when it lands in the
    // slot that becomes the head (empty queue, or push+pop with one entry).
    always_comb begin
        head_load_s = (push_s || pop_s) && (count_n_s != 2'd0);
        head_data_s = out_data_r;
        head_tag_s  = out_tag_r;
        head_ill_s  = out_illegal_r;
        if (push_s && (wr_ptr_r == rd_n_s)) begin
            head_data_s = new_data_s;
            head_tag_s  = in_tag;
            head_ill_s  = new_ill_s;
        end else begin
            head_data_s = mem_data_r[rd_n_s];
            head_tag_s  = mem_tag_r[rd_n_s];
            head_ill_s  = mem_ill_r[rd_n_s];
        end
    end

    // Pointers, occupancy and handshake flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r    <= 1'b0;
            rd_ptr_r    <= 1'b0;
            count_r     <= 2'd0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            wr_ptr_r    <= wr_ptr_r ^ push_s;
            rd_ptr_r    <= rd_n_s;
            count_r     <= count_n_s;
            in_ready_r  <= (count_n_s != 2'd2);
            out_valid_r <= (count_n_s != 2'd0);
        end
    end

    // Queue storage; written only on an accepted push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mem_data_r[i] <= '0;
                mem_tag_r[i]  <= '0;
                mem_ill_r[i]  <= 1'b0;
            end
        end else if (push_s) begin
            mem_data_r[wr_ptr_r] <= new_data_s;
            mem_tag_r[wr_ptr_r]  <= in_tag;
            mem_ill_r[wr_ptr_r]  <= new_ill_s;
        end else begin
            mem_data_r <= mem_data_r;
            mem_tag_r  <= mem_tag_r;
            mem_ill_r  <= mem_ill_r;
        end
    end

    // Registered head-of-queue outputs; they hold while stalled or emptied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_r    <= '0;
            out_tag_r     <= '0;
            out_illegal_r <= 1'b0;
        end else if (head_load_s) begin
            out_data_r    <= head_data_s;
            out_tag_r     <= head_tag_s;
            out_illegal_r <= head_ill_s;
        end else begin
            out_data_r    <= out_data_r;
            out_tag_r     <= out_tag_r;
            out_illegal_r <= out_illegal_r;
        end
    end

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign out_data    = out_data_r;
    assign out_tag     = out_tag_r;
    assign out_illegal = out_illegal_r;

endmodule

// File: tb/tb_fpu_sgnj_stage.sv
module tb_fpu_sgnj_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic        in_fmt;
    logic [63:0] in_rs1;
    logic [63:0] in_rs2;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [4:0]  out_tag;
    logic        out_illegal;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [63:0] data;
        logic [4:0]  tag;
        logic        ill;
    } entry_t;

    entry_t q[$];

    fpu_sgnj_stage #(.BUS_WIDTH(64), .TAG_WIDTH(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_fmt(in_fmt),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag), .out_illegal(out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // Reference: value-level description of sign injection.
    function automatic logic [63:0] ref_model(input logic [1:0] op, input logic fmt,
                                              input logic [63:0] a, input logic [63:0] b);
        logic [63:0] ua, ub, mag;
        logic sa, sb, s;
        int w;
        if (op == 2'd3) return a;
        w = fmt ? 64 : 32;
        ua = a; ub = b;
        if (!fmt) begin
            ua = (a >> 32) == 64'h0000_0000_FFFF_FFFF ? (a & 64'hFFFF_FFFF) : 64'h7FC0_0000;
            ub = (b >> 32) == 64'h0000_0000_FFFF_FFFF ? (b & 64'hFFFF_FFFF) : 64'h7FC0_0000;
        end
        sa  = ((ua >> (w - 1)) & 64'd1) != 64'd0;
        sb  = ((ub >> (w - 1)) & 64'd1) != 64'd0;
        s   = (op == 2'd0) ? sb : (op == 2'd1) ? !sb : (sa != sb);
        mag = ua % (64'd1 << (w - 1));
        if (fmt) return mag + (s ? (64'd1 << 63) : 64'd0);
        return 64'hFFFF_FFFF_0000_0000 + mag + (s ? 64'h8000_0000 : 64'd0);
    endfunction

    // One clock: drive inputs, check outputs against the model, advance model.
    task automatic cycle(input bit v, input logic [1:0] op, input bit fmt,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] tag, input bit ordy);
        bit acc, pp;
        entry_t e;
        in_valid = v; in_op = op; in_fmt = fmt; in_rs1 = a; in_rs2 = b;
        in_tag = tag; out_ready = ordy;
        #1;
        chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() != 0});
        chk("in_ready", {63'd0, in_ready}, {63'd0, q.size() != 2});
        if (q.size() != 0) begin
            chk("out_data", out_data, q[0].data);
            chk("out_tag", {59'd0, out_tag}, {59'd0, q[0].tag});
            chk("out_illegal", {63'd0, out_illegal}, {63'd0, q[0].ill});
        end
        acc = v && (q.size() != 2);
        pp  = ordy && (q.size() != 0);
        @(posedge clk);
        if (pp) void'(q.pop_front());
        if (acc) begin
            e.data = ref_model(op, fmt, a, b);
            e.tag  = tag;
            e.ill  = (op == 2'd3);
            q.push_back(e);
        end
        @(negedge clk);
    endtask

    function automatic logic [63:0] rnd_operand();
        logic [63:0] x;
        x = {$urandom(), $urandom()};
        if ($urandom_range(0, 3) != 0) x[63:32] = 32'hFFFF_FFFF;
        return x;
    endfunction

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_op = 2'd0; in_fmt = 1'b0;
        in_rs1 = 64'd0; in_rs2 = 64'd0; in_tag = 5'd0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_out_data", out_data, 64'd0);
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        rst_n = 1'b1;

        // Reset state and idle cycle
        cycle(1'b0, 2'd0, 1'b0, 64'd0, 64'd0, 5'd0, 1'b1);

        // Double FSGNJX
        cycle(1'b1, 2'd2, 1'b1, 64'h3FF0_0000_0000_0000, 64'hC000_0000_0000_0000, 5'd9, 1'b1);
        chk("dx_valid", {63'd0, out_valid}, 64'd1);
        chk("dx_data", out_data, 64'hBFF0_0000_0000_0000);
        chk("dx_tag", {59'd0, out_tag}, 64'd9);

        // Single FSGNJN
        cycle(1'b1, 2'd1, 1'b0, 64'hFFFF_FFFF_3F80_0000, 64'hFFFF_FFFF_3F80_0000, 5'd4, 1'b1);
        chk("sn_data", out_data, 64'hFFFF_FFFF_BF80_0000);

        // Single FSGNJ with bad boxing on rs1
        cycle(1'b1, 2'd0, 1'b0, 64'h0000_0000_3F80_0000, 64'hFFFF_FFFF_BF80_0000, 5'd6, 1'b1);
        chk("sj_unbox_data", out_data, 64'hFFFF_FFFF_FFC0_0000);
        cycle(1'b0, 2'd0, 1'b0, 64'd0, 64'd0, 5'd0, 1'b1);

        // Backpressure: tags 1,2,3 with out_ready low
        cycle(1'b1, 2'd0, 1'b1, 64'h1, 64'h0, 5'd1, 1'b0);
        cycle(1'b1, 2'd0, 1'b1, 64'h2, 64'h0, 5'd2, 1'b0);
        chk("bp_full_in_ready", {63'd0, in_ready}, 64'd0);
        cycle(1'b1, 2'd0, 1'b1, 64'h3, 64'h0, 5'd3, 1'b0);
        chk("bp_hold_tag", {59'd0, out_tag}, 64'd1);
        chk("bp_hold_in_ready", {63'd0, in_ready}, 64'd0);
        cycle(1'b1, 2'd0, 1'b1, 64'h3, 64'h0, 5'd3, 1'b1);
        chk("bp_tag2", {59'd0, out_tag}, 64'd2);
        cycle(1'b1, 2'd0, 1'b1, 64'h3, 64'h0, 5'd3, 1'b1);
        chk("bp_tag3", {59'd0, out_tag}, 64'd3);
        chk("bp_tag3_valid", {63'd0, out_valid}, 64'd1);
        cycle(1'b0, 2'd0, 1'b0, 64'd0, 64'd0, 5'd0, 1'b1);
        chk("bp_drained", {63'd0, out_valid}, 64'd0);

        // Reserved opcode followed by a legal op
        cycle(1'b1, 2'd3, 1'b1, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_0000_FFFF_0000, 5'd7, 1'b1);
        chk("rsvd_data", out_data, 64'h1234_5678_9ABC_DEF0);
        chk("rsvd_illegal", {63'd0, out_illegal}, 64'd1);
        cycle(1'b1, 2'd0, 1'b1, 64'h4000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd8, 1'b1);
        chk("legal_after_rsvd", {63'd0, out_illegal}, 64'd0);
        chk("legal_after_rsvd_data", out_data, 64'hC000_0000_0000_0000);
        cycle(1'b0, 2'd0, 1'b0, 64'd0, 64'd0, 5'd0, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  rnd_operand(), rnd_operand(), 5'($urandom_range(0, 31)),
                  $urandom_range(0, 2) != 0);
        end

        // Reset with two entries queued and writeback stalled
        while (q.size() != 0) cycle(1'b0, 2'd0, 1'b0, 64'd0, 64'd0, 5'd0, 1'b1);
        cycle(1'b1, 2'd0, 1'b1, 64'h11, 64'h0, 5'd11, 1'b0);
        cycle(1'b1, 2'd0, 1'b1, 64'h12, 64'h0, 5'd12, 1'b0);
        chk("pre_rst_full", {63'd0, in_ready}, 64'd0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_async_out_valid", {63'd0, out_valid}, 64'd0);
        q.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b0, 2'd0, 1'b0, 64'd0, 64'd0, 5'd0, 1'b1);
        chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("post_rst_out_data", out_data, 64'd0);
        cycle(1'b0, 2'd0, 1'b0, 64'd0, 64'd0, 5'd0, 1'b1);
        cycle(1'b1, 2'd1, 1'b1, 64'h3FF0_0000_0000_0000, 64'h0, 5'd13, 1'b1);
        chk("post_rst_first_tag", {59'd0, out_tag}, 64'd13);
        cycle(1'b0, 2'd0, 1'b0, 64'd0, 64'd0, 5'd0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
